// File: rtl/dvi_seq_pkg.sv
// Shared types and helpers for the DVI video sequencer.
//   seq_state_e : sequencer FSM state
//   colour_t    : {r, g, b} pixel, 8 bits per channel
//   COUNT_W     : width of the raster counters
//   in_region() : true when a counter lies in [start, start + len)
package dvi_seq_pkg;

  localparam int unsigned COUNT_W = 12;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StStopping
  } seq_state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } colour_t;

  function automatic logic in_region(logic [COUNT_W-1:0] cnt, int unsigned start,
                                     int unsigned len);
    return (32'(cnt) >= start) && (32'(cnt) < start + len);
  endfunction

endpackage

// File: rtl/dvi_raster_counter.sv
// Horizontal/vertical raster counters with region flags.
// Origin (0,0) is the first active pixel; each axis runs active, front porch,
// sync, back porch. Counters are held at 0 while i_run is low.
//   i_clk, i_rst : pixel clock, synchronous active-high reset
//   i_run        : advance counters this cycle
//   o_h, o_v     : current column / line
//   o_active     : (o_h, o_v) is inside the active picture
//   o_hsync      : o_h is inside the hsync region
//   o_vsync      : o_v is inside the vsync region
//   o_last       : last pixel of the frame
module dvi_raster_counter
  import dvi_seq_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_run,
  output logic [COUNT_W-1:0] o_h,
  output logic [COUNT_W-1:0] o_v,
  output logic               o_active,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_last
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [COUNT_W-1:0] HLast = COUNT_W'(HTotal - 1);
  localparam logic [COUNT_W-1:0] VLast = COUNT_W'(VTotal - 1);

  logic [COUNT_W-1:0] h_q, h_d, v_q, v_d;
  logic               h_wrap, v_wrap;

  always_comb begin
    h_wrap = (h_q == HLast);
    v_wrap = (v_q == VLast);
    h_d    = h_q;
    v_d    = v_q;
    if (!i_run) begin
      h_d = '0;
      v_d = '0;
    end else if (h_wrap) begin
      h_d = '0;
      v_d = v_wrap ? '0 : v_q + COUNT_W'(1);
    end else begin
      h_d = h_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign o_h      = h_q;
  assign o_v      = v_q;
  assign o_active = (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);
  assign o_hsync  = in_region(h_q, H_ACTIVE + H_FP, H_SYNC);
  assign o_vsync  = in_region(v_q, V_ACTIVE + V_FP, V_SYNC);
  assign o_last   = h_wrap && v_wrap;

endmodule

// File: rtl/dvi_video_sequencer.sv
// Raster timing and pixel fetch for three TMDS DVI encoders.
// Counter state at cycle t produces the FIFO read strobe at t+1 and the
// registered DE/sync/colour/position at t+2. Start and stop are frame aligned;
// an empty FIFO on an active pixel yields black and sets a sticky flag.
// Optional build macro DVI_SEQ_TEST_PATTERN_EN adds i_test (8 colour bars,
// no FIFO reads, no underrun).
//   i_clk, i_rst        : pixel clock, synchronous active-high reset
//   i_en                : run request (level)
//   i_pix_data/_empty   : show-ahead FIFO head and empty flag
//   o_pix_rd            : FIFO pop strobe, one cycle ahead of o_de
//   i_underrun_clr      : clears o_underrun (a new underrun wins)
//   o_de, o_ctrl_b      : encoder DE and blue-channel {vsync, hsync}
//   o_r, o_g, o_b       : encoder pixel data
//   o_x, o_y            : position of the current o_de pixel
//   o_frame_start       : pulse with the first DE pixel of a frame
//   o_underrun, o_busy  : sticky underrun flag, sequencer not idle
module dvi_video_sequencer
  import dvi_seq_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic [23:0]        i_pix_data,
  input  logic               i_pix_empty,
`ifdef DVI_SEQ_TEST_PATTERN_EN
  input  logic               i_test,
`endif
  input  logic               i_underrun_clr,
  output logic               o_pix_rd,
  output logic               o_de,
  output logic [1:0]         o_ctrl_b,
  output logic [7:0]         o_r,
  output logic [7:0]         o_g,
  output logic [7:0]         o_b,
  output logic [COUNT_W-1:0] o_x,
  output logic [COUNT_W-1:0] o_y,
  output logic               o_frame_start,
  output logic               o_underrun,
  output logic               o_busy
);

  seq_state_e         state_q, state_d;
  logic               run;
  logic               test_mode;

  logic [COUNT_W-1:0] h_cnt, v_cnt;
  logic               active, hsync_act, vsync_act, last_pix;

  // Stage 1: registered one cycle after the counter state
  logic               rd_q, rd_d;
  logic               s1_de_q, s1_hs_q, s1_vs_q, s1_fs_q;
  logic [COUNT_W-1:0] s1_x_q, s1_y_q;
  logic               underrun_q, underrun_d, under_set;

  // Stage 2: encoder-facing registers
  logic               de_q, fs_q;
  logic [1:0]         ctrl_q;
  logic [COUNT_W-1:0] x_q, y_q;
  colour_t            colour_q, colour_d;

  dvi_raster_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_raster (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_run    (run),
    .o_h      (h_cnt),
    .o_v      (v_cnt),
    .o_active (active),
    .o_hsync  (hsync_act),
    .o_vsync  (vsync_act),
    .o_last   (last_pix)
  );

`ifdef DVI_SEQ_TEST_PATTERN_EN
  logic [2:0] bar_idx;
  assign test_mode = i_test;
  assign bar_idx   = 3'((32'(s1_x_q) * 32'd8) / H_ACTIVE);
`else
  assign test_mode = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (i_en) state_d = StRun;
      StRun:      if (!i_en) state_d = StStopping;
      StStopping: begin
        // A re-request wins over the frame end so timing is never disturbed
        if (i_en)          state_d = StRun;
        else if (last_pix) state_d = StIdle;
      end
      default:    state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    run    = (state_q != StIdle);
    o_busy = run;
  end

  always_comb begin
    rd_d       = run && active && !i_pix_empty && !test_mode;
    under_set  = run && active && i_pix_empty && !test_mode;
    underrun_d = under_set | (underrun_q & ~i_underrun_clr);
  end

  always_comb begin
    colour_d = '0;
    if (rd_q) colour_d = i_pix_data;
`ifdef DVI_SEQ_TEST_PATTERN_EN
    if (test_mode && s1_de_q) begin
      colour_d = '{r: {8{bar_idx[2]}}, g: {8{bar_idx[1]}}, b: {8{bar_idx[0]}}};
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_q       <= 1'b0;
      s1_de_q    <= 1'b0;
      s1_hs_q    <= 1'b0;
      s1_vs_q    <= 1'b0;
      s1_fs_q    <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      underrun_q <= 1'b0;
      de_q       <= 1'b0;
      fs_q       <= 1'b0;
      ctrl_q     <= {~V_POL, ~H_POL};
      x_q        <= '0;
      y_q        <= '0;
      colour_q   <= '0;
    end else begin
      rd_q       <= rd_d;
      s1_de_q    <= run && active;
      s1_hs_q    <= run && hsync_act;
      s1_vs_q    <= run && vsync_act;
      s1_fs_q    <= run && (h_cnt == '0) && (v_cnt == '0);
      s1_x_q     <= h_cnt;
      s1_y_q     <= v_cnt;
      underrun_q <= underrun_d;
      de_q       <= s1_de_q;
      fs_q       <= s1_fs_q;
      ctrl_q     <= {s1_vs_q ? V_POL : ~V_POL, s1_hs_q ? H_POL : ~H_POL};
      x_q        <= s1_x_q;
      y_q        <= s1_y_q;
      colour_q   <= colour_d;
    end
  end

  assign o_pix_rd      = rd_q;
  assign o_de          = de_q;
  assign o_ctrl_b      = ctrl_q;
  assign o_r           = colour_q.r;
  assign o_g           = colour_q.g;
  assign o_b           = colour_q.b;
  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_frame_start = fs_q;
  assign o_underrun    = underrun_q;

endmodule

// File: tb/tb_dvi_video_sequencer.sv
// Bench for dvi_video_sequencer on a small 8x6 raster (48-cycle frame).
// Reference model: frame position as a plain integer, outputs derived from
// the counter history two cycles back.
module tb_dvi_video_sequencer;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst, en, pix_empty, clr;
  logic [23:0] pix_data;
  bit          test;
  logic        o_pix_rd, o_de, o_frame_start, o_underrun, o_busy;
  logic [1:0]  o_ctrl_b;
  logic [7:0]  o_r, o_g, o_b;
  logic [11:0] o_x, o_y;

  always #5 clk = ~clk;

  dvi_video_sequencer #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .H_POL    (1'b0), .V_POL (1'b0)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_en           (en),
    .i_pix_data     (pix_data),
    .i_pix_empty    (pix_empty),
`ifdef DVI_SEQ_TEST_PATTERN_EN
    .i_test         (test),
`endif
    .i_underrun_clr (clr),
    .o_pix_rd       (o_pix_rd),
    .o_de           (o_de),
    .o_ctrl_b       (o_ctrl_b),
    .o_r            (o_r),
    .o_g            (o_g),
    .o_b            (o_b),
    .o_x            (o_x),
    .o_y            (o_y),
    .o_frame_start  (o_frame_start),
    .o_underrun     (o_underrun),
    .o_busy         (o_busy)
  );

  typedef struct {
    bit          busy;
    int          pos;
    bit          en;
    bit          empty;
    bit          clr;
    bit          test;
    bit          rst;
    logic [23:0] data;
  } rec_t;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          m_busy, m_stop, m_und;
  int          m_pos;
  rec_t        r1, r2;
  logic [23:0] fifo_val;
  logic [54:0] exp_vec;

  function automatic bit m_active(rec_t r);
    return r.busy && ((r.pos % HT) < HA) && ((r.pos / HT) < VA);
  endfunction

  function automatic logic [54:0] act_vec();
    return {o_de, o_ctrl_b, o_r, o_g, o_b, o_x, o_y, o_frame_start, o_underrun, o_busy,
            o_pix_rd};
  endfunction

  // One clock: advance the model across the edge and form the expected outputs.
  task automatic step();
    rec_t        cur;
    bit          pop, last, ok2, a2, e_hs, e_vs, e_fs, e_rd;
    int          h2, v2, k;
    logic [23:0] rgb;
    logic [7:0]  kb;
    cur = '{busy: m_busy, pos: m_pos, en: en, empty: pix_empty, clr: clr, test: test,
            rst: rst, data: pix_data};
    pop = (o_pix_rd === 1'b1);
    @(posedge clk);
    #1;
    cyc++;
    if (cur.rst) begin
      m_busy = 0; m_stop = 0; m_pos = 0; m_und = 0;
    end else begin
      m_und = (m_active(cur) && cur.empty && !cur.test) || (m_und && !cur.clr);
      if (!m_busy) begin
        if (cur.en) m_busy = 1;
        m_pos = 0;
      end else begin
        last  = (m_pos == FT - 1);
        m_pos = (m_pos + 1) % FT;
        if (m_stop) begin
          if (cur.en) m_stop = 0;
          else if (last) m_busy = 0;
        end else if (!cur.en) begin
          m_stop = 1;
        end
      end
    end
    r2 = r1;
    r1 = cur;
    if (pop) fifo_val = fifo_val + 24'd1;
    pix_data = fifo_val;

    h2   = r2.pos % HT;
    v2   = r2.pos / HT;
    ok2  = !r1.rst && !r2.rst;
    a2   = ok2 && m_active(r2);
    e_rd = !r1.rst && m_active(r1) && !r1.empty && !r1.test;
    e_hs = ok2 && r2.busy && (h2 >= HA + HF) && (h2 < HA + HF + HS);
    e_vs = ok2 && r2.busy && (v2 >= VA + VF) && (v2 < VA + VF + VS);
    e_fs = ok2 && r2.busy && (r2.pos == 0);
    rgb  = '0;
    if (a2 && r1.test) begin
      k   = (h2 * 8) / HA;
      kb  = 8'(k);
      rgb = {kb[2] ? 8'hFF : 8'h00, kb[1] ? 8'hFF : 8'h00, kb[0] ? 8'hFF : 8'h00};
    end else if (a2 && !r2.empty && !r2.test) begin
      rgb = r1.data;
    end
    exp_vec = {a2, ~e_vs, ~e_hs, rgb, ok2 ? 12'(h2) : 12'd0, ok2 ? 12'(v2) : 12'd0, e_fs,
               m_und, m_busy, e_rd};
  endtask

  // Steps until the model counters reach position p (running frame assumed).
  task automatic goto_pos(input int p, input string name);
    int n;
    n = (p - m_pos + FT) % FT;
    for (int i = 0; i < n; i++) begin
      step();
      n_assert++;
      if (act_vec() !== exp_vec) begin
        n_fail++;
        $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act_vec(), exp_vec);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1; en = 0; pix_empty = 0; clr = 0; test = 0;
    for (int i = 0; i < 3; i++) step();
    n_assert++;
    if ({o_de, o_pix_rd, o_frame_start, o_underrun, o_busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags got=%b exp=00000",
               {o_de, o_pix_rd, o_frame_start, o_underrun, o_busy});
    end
    n_assert++;
    if (o_ctrl_b !== 2'b11) begin
      n_fail++; $display("FAIL reset_ctrl got=%b exp=11", o_ctrl_b);
    end
    n_assert++;
    if ({o_r, o_g, o_b, o_x, o_y} !== 48'd0) begin
      n_fail++; $display("FAIL reset_data got=%h exp=0", {o_r, o_g, o_b, o_x, o_y});
    end
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_assert++;
      if (act_vec() !== exp_vec) begin
        n_fail++; $display("FAIL idle cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec);
      end
    end
  endtask

  task automatic test_frame_timing();
    int lat, de_cnt, hs_cnt, vs_cnt, vs_run, vs_max, rd_cnt;
    fifo_val = 24'd1; pix_data = fifo_val; pix_empty = 0; en = 1;
    lat = 0;
    while (lat < 10 && o_frame_start !== 1'b1) begin
      step();
      lat++;
      n_assert++;
      if (act_vec() !== exp_vec) begin
        n_fail++; $display("FAIL start cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec);
      end
    end
    n_assert++;
    if (lat != 3) begin
      n_fail++; $display("FAIL frame_start_latency got=%0d exp=3", lat);
    end
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; vs_run = 0; vs_max = 0; rd_cnt = 0;
    for (int k = 0; k < FT; k++) begin
      if (k < HA) begin
        n_assert++;
        if ({o_de, o_b, o_x, o_y} !== {1'b1, 8'(k + 1), 12'(k), 12'd0}) begin
          n_fail++;
          $display("FAIL line0_pixel k=%0d got de=%b b=%0d x=%0d y=%0d exp b=%0d x=%0d",
                   k, o_de, o_b, o_x, o_y, k + 1, k);
        end
      end
      de_cnt += int'(o_de === 1'b1);
      rd_cnt += int'(o_pix_rd === 1'b1);
      hs_cnt += int'(o_ctrl_b[0] === 1'b0);
      vs_cnt += int'(o_ctrl_b[1] === 1'b0);
      vs_run  = (o_ctrl_b[1] === 1'b0) ? vs_run + 1 : 0;
      if (vs_run > vs_max) vs_max = vs_run;
      step();
      n_assert++;
      if (act_vec() !== exp_vec) begin
        n_fail++; $display("FAIL frame cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec);
      end
    end
    n_assert++;
    if (de_cnt != HA * VA) begin
      n_fail++; $display("FAIL de_per_frame got=%0d exp=%0d", de_cnt, HA * VA);
    end
    n_assert++;
    if (rd_cnt != HA * VA) begin
      n_fail++; $display("FAIL reads_per_frame got=%0d exp=%0d", rd_cnt, HA * VA);
    end
    n_assert++;
    if (hs_cnt != HS * VT) begin
      n_fail++; $display("FAIL hsync_cycles got=%0d exp=%0d", hs_cnt, HS * VT);
    end
    n_assert++;
    if (vs_cnt != VS * HT || vs_max != VS * HT) begin
      n_fail++;
      $display("FAIL vsync_cycles got=%0d run=%0d exp=%0d", vs_cnt, vs_max, VS * HT);
    end
  endtask

  task automatic test_underrun();
    goto_pos(1 * HT + 2, "underrun_seek");
    pix_empty = 1;
    step();
    pix_empty = 0;
    n_assert++;
    if (o_underrun !== 1'b1) begin
      n_fail++; $display("FAIL underrun_set got=%b exp=1", o_underrun);
    end
    step();
    n_assert++;
    if ({o_de, o_x, o_y, o_r, o_g, o_b} !== {1'b1, 12'd2, 12'd1, 24'd0}) begin
      n_fail++;
      $display("FAIL underrun_black got de=%b x=%0d y=%0d rgb=%h exp de=1 x=2 y=1 rgb=0",
               o_de, o_x, o_y, {o_r, o_g, o_b});
    end
    goto_pos((m_pos + 6) % FT, "underrun_hold");
    n_assert++;
    if (o_underrun !== 1'b1) begin
      n_fail++; $display("FAIL underrun_held got=%b exp=1", o_underrun);
    end
    clr = 1;
    step();
    clr = 0;
    n_assert++;
    if (o_underrun !== 1'b0) begin
      n_fail++; $display("FAIL underrun_clear got=%b exp=0", o_underrun);
    end
    goto_pos(2 * HT + 1, "underrun_seek2");
    pix_empty = 1; clr = 1;
    step();
    pix_empty = 0; clr = 0;
    n_assert++;
    if (o_underrun !== 1'b1) begin
      n_fail++; $display("FAIL underrun_set_beats_clr got=%b exp=1", o_underrun);
    end
    clr = 1;
    goto_pos((m_pos + 1) % FT, "underrun_clr2");
    clr = 0;
  endtask

  task automatic test_stop_restart();
    int n, gap;
    goto_pos(20, "stop_seek");
    en = 0;
    n = 0;
    while (n < 3 * FT && o_busy === 1'b1) begin
      step();
      n++;
      n_assert++;
      if (act_vec() !== exp_vec) begin
        n_fail++; $display("FAIL stop cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec);
      end
    end
    n_assert++;
    if (o_busy !== 1'b0 || n != FT - 20) begin
      n_fail++; $display("FAIL stop_latency got=%0d busy=%b exp=%0d", n, o_busy, FT - 20);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      n_assert++;
      if ({o_de, o_ctrl_b, o_pix_rd, o_busy} !== 5'b01100) begin
        n_fail++;
        $display("FAIL idle_outputs got=%b exp=01100", {o_de, o_ctrl_b, o_pix_rd, o_busy});
      end
    end
    en = 1;
    n = 0;
    while (n < 2 * FT && o_frame_start !== 1'b1) begin
      step();
      n++;
    end
    gap = 0;
    do begin
      if (m_pos == 30) en = 0;
      if (m_pos == 40) en = 1;
      step();
      gap++;
      n_assert++;
      if (act_vec() !== exp_vec) begin
        n_fail++; $display("FAIL restart cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec);
      end
    end while (gap < 3 * FT && o_frame_start !== 1'b1);
    n_assert++;
    if (gap != FT || o_busy !== 1'b1) begin
      n_fail++; $display("FAIL reenable_cadence got=%0d busy=%b exp=%0d", gap, o_busy, FT);
    end
  endtask

  task automatic test_reset_mid();
    goto_pos(1 * HT + 1, "rstmid_seek");
    step(); step();
    n_assert++;
    if (o_de !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_active got=%b exp=1", o_de);
    end
    rst = 1;
    step();
    rst = 0;
    n_assert++;
    if ({o_de, o_ctrl_b, o_pix_rd, o_busy} !== 5'b01100) begin
      n_fail++;
      $display("FAIL rstmid_outputs got=%b exp=01100", {o_de, o_ctrl_b, o_pix_rd, o_busy});
    end
    for (int i = 0; i < 8; i++) begin
      step();
      n_assert++;
      if (act_vec() !== exp_vec) begin
        n_fail++; $display("FAIL rstmid cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec);
      end
    end
  endtask

  task automatic test_random();
    fifo_val = 24'($urandom);
    pix_data = fifo_val;
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 39) == 0) en = ~en;
      pix_empty = ($urandom_range(0, 4) == 0);
      clr       = ($urandom_range(0, 6) == 0);
      rst       = ($urandom_range(0, 249) == 0);
      step();
      n_assert++;
      if (act_vec() !== exp_vec) begin
        n_fail++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec);
      end
    end
    rst = 0; pix_empty = 0; clr = 0;
  endtask

`ifdef DVI_SEQ_TEST_PATTERN_EN
  task automatic test_pattern();
    test = 1; en = 1;
    for (int i = 0; i < 2 * FT; i++) begin
      step();
      n_assert++;
      if (act_vec() !== exp_vec || o_pix_rd !== 1'b0) begin
        n_fail++; $display("FAIL pattern cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec);
      end
    end
    test = 0;
  endtask
`endif

  initial begin
    rst = 1; en = 0; pix_empty = 0; clr = 0; test = 0;
    fifo_val = 24'd1; pix_data = fifo_val;
    m_busy = 0; m_stop = 0; m_und = 0; m_pos = 0;
    r1 = '{busy: 0, pos: 0, en: 0, empty: 0, clr: 0, test: 0, rst: 1, data: '0};
    r2 = r1;
    test_reset();
    test_frame_timing();
    test_underrun();
    test_stop_restart();
    test_reset_mid();
    test_random();
`ifdef DVI_SEQ_TEST_PATTERN_EN
    rst = 1; step(); rst = 0;
    test_pattern();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
